// File: rtl/gb_cpu_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : gb_cpu_sequencer_if
// Brief    : Sequencer <-> fetch/decoder signal bundle. The master side is the
//            sequencer; the slave side is the bus fetch path plus decoder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface gb_cpu_sequencer_if #(
    parameter int MAX_MCYCLES   = 6,
    parameter int TCYCLES_PER_M = 4
);
    localparam int LEN_W = $clog2(MAX_MCYCLES + 1);
    localparam int IDX_W = $clog2(MAX_MCYCLES);
    localparam int TC_W  = $clog2(TCYCLES_PER_M);

    // Fetch path / decoder -> sequencer
    logic [7:0]       opcode_in;
    logic [LEN_W-1:0] sched_len;
    logic             cond_fail;
    logic             irq_pending;
    logic             ime;

    // Sequencer -> decoder / datapath
    logic [7:0]       ir_opcode;
    logic             cb_prefix;
    logic             isr_cmd;
    logic [IDX_W-1:0] mcycle_idx;
    logic [TC_W-1:0]  tcycle_idx;
    logic             m_last;
    logic             fetch_en;
    logic             pc_inc;
    logic             instr_done;
    logic             halted;
    logic             sched_err;

    modport master (
        input  opcode_in, sched_len, cond_fail, irq_pending, ime,
        output ir_opcode, cb_prefix, isr_cmd, mcycle_idx, tcycle_idx,
               m_last, fetch_en, pc_inc, instr_done, halted, sched_err
    );

    modport slave (
        output opcode_in, sched_len, cond_fail, irq_pending, ime,
        input  ir_opcode, cb_prefix, isr_cmd, mcycle_idx, tcycle_idx,
               m_last, fetch_en, pc_inc, instr_done, halted, sched_err
    );
endinterface

`default_nettype wire

// File: rtl/gb_cpu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : gb_cpu_sequencer
// Brief    : M-cycle/T-cycle sequencer. Owns IR, CB-prefix latch, ISR-dispatch
//            flag and HALT state; steps each decoded schedule and overlaps the
//            next opcode fetch with the last M-cycle of the current one.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module gb_cpu_sequencer #(
    parameter int         MAX_MCYCLES   = 6,
    parameter int         TCYCLES_PER_M = 4,
    parameter logic [7:0] HALT_OPCODE   = 8'h76,
    parameter logic [7:0] CB_OPCODE     = 8'hCB
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    gb_cpu_sequencer_if.master  bus
);
    localparam int LEN_W = $clog2(MAX_MCYCLES + 1);
    localparam int IDX_W = $clog2(MAX_MCYCLES);
    localparam int TC_W  = $clog2(TCYCLES_PER_M);

    localparam logic [TC_W-1:0]  C_T_LAST  = TC_W'(TCYCLES_PER_M - 1);
    localparam logic [LEN_W-1:0] C_LEN_MAX = LEN_W'(MAX_MCYCLES);
    localparam logic [LEN_W-1:0] C_LEN_ONE = LEN_W'(1);

    typedef enum logic [0:0] {
        ST_EXEC = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           state_q,  state_d;
    logic [TC_W-1:0]  tcycle_q;
    logic [IDX_W-1:0] mcycle_q, mcycle_d;
    logic [7:0]       ir_q,     ir_d;
    logic             cb_q,     cb_d;
    logic             isr_q,    isr_d;
    logic             err_q,    err_d;

    logic             w_m_end;
    logic             w_range_err;
    logic [LEN_W-1:0] w_eff_len;
    logic [LEN_W-1:0] w_last_idx;
    logic             w_prefix_cyc;
    logic             w_cond_end;
    logic             w_idx_last;
    logic             w_m_last;
    logic             w_fetch_en;
    logic             w_pc_inc;
    logic             w_instr_done;

    // Schedule-length clamping and end-of-M-cycle detection
    always_comb begin
        w_m_end     = (tcycle_q == C_T_LAST);
        w_range_err = (bus.sched_len == '0) || (bus.sched_len > C_LEN_MAX);
        if (bus.sched_len == '0) begin
            w_eff_len = C_LEN_ONE;
        end else if (bus.sched_len > C_LEN_MAX) begin
            w_eff_len = C_LEN_MAX;
        end else begin
            w_eff_len = bus.sched_len;
        end
        w_last_idx   = w_eff_len - C_LEN_ONE;
        w_idx_last   = (LEN_W'(mcycle_q) == w_last_idx);
        // The prefix byte itself is always a single M-cycle that fetches the operand
        w_prefix_cyc = (ir_q == CB_OPCODE) && !cb_q && !isr_q;
        // A failed condition cannot shorten the ISR or the prefix cycle
        w_cond_end   = bus.cond_fail && !isr_q && !w_prefix_cyc;
    end

    // T-cycle counter free-runs and wraps every M-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcycle_q <= '0;
        end else if (w_m_end) begin
            tcycle_q <= '0;
        end else begin
            tcycle_q <= tcycle_q + TC_W'(1);
        end
    end

    // Sequencer state registers; all update only on an M-cycle boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EXEC;
            mcycle_q <= '0;
            ir_q     <= 8'h00;
            cb_q     <= 1'b0;
            isr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcycle_q <= mcycle_d;
            ir_q     <= ir_d;
            cb_q     <= cb_d;
            isr_q    <= isr_d;
            err_q    <= err_d;
        end
    end

    // Next-state and control decode for EXEC/HALT
    always_comb begin
        state_d      = state_q;
        mcycle_d     = mcycle_q;
        ir_d         = ir_q;
        cb_d         = cb_q;
        isr_d        = isr_q;
        err_d        = err_q;
        w_m_last     = 1'b0;
        w_fetch_en   = 1'b0;
        w_pc_inc     = 1'b0;
        w_instr_done = 1'b0;

        case (state_q)
            ST_EXEC: begin
                w_m_last   = w_prefix_cyc || w_idx_last || w_cond_end;
                w_fetch_en = w_m_last;
                if (w_m_end) begin
                    // sched_len is not consulted on the prefix cycle
                    if (!w_prefix_cyc && w_range_err) begin
                        err_d = 1'b1;
                    end
                    if (!w_m_last) begin
                        mcycle_d = mcycle_q + IDX_W'(1);
                    end else begin
                        w_instr_done = 1'b1;
                        mcycle_d     = '0;
                        if (isr_q) begin
                            isr_d    = 1'b0;
                            ir_d     = bus.opcode_in;
                            cb_d     = 1'b0;
                            w_pc_inc = 1'b1;
                        end else if (w_prefix_cyc) begin
                            // No interrupt window between prefix and operand
                            cb_d     = 1'b1;
                            ir_d     = bus.opcode_in;
                            w_pc_inc = 1'b1;
                        end else if ((ir_q == HALT_OPCODE) && !cb_q && !bus.irq_pending) begin
                            state_d = ST_HALT;
                            cb_d    = 1'b0;
                        end else if (bus.irq_pending && bus.ime) begin
                            // IR held; fetched byte dropped, PC not advanced
                            isr_d = 1'b1;
                            cb_d  = 1'b0;
                        end else begin
                            ir_d     = bus.opcode_in;
                            cb_d     = 1'b0;
                            w_pc_inc = 1'b1;
                        end
                    end
                end
            end

            ST_HALT: begin
                // Keep re-reading PC so the wake-up opcode is ready
                w_fetch_en = 1'b1;
                mcycle_d   = '0;
                if (w_m_end && bus.irq_pending) begin
                    state_d = ST_EXEC;
                    if (bus.ime) begin
                        isr_d = 1'b1;
                    end else begin
                        ir_d     = bus.opcode_in;
                        w_pc_inc = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_EXEC;
            end
        endcase
    end

    assign bus.ir_opcode  = ir_q;
    assign bus.cb_prefix  = cb_q;
    assign bus.isr_cmd    = isr_q;
    assign bus.mcycle_idx = mcycle_q;
    assign bus.tcycle_idx = tcycle_q;
    assign bus.m_last     = w_m_last;
    assign bus.fetch_en   = w_fetch_en;
    assign bus.pc_inc     = w_pc_inc;
    assign bus.instr_done = w_instr_done;
    assign bus.halted     = (state_q == ST_HALT);
    assign bus.sched_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_gb_cpu_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_gb_cpu_sequencer
// Brief    : Directed bench for gb_cpu_sequencer (MAX_MCYCLES=6, 4 T/M).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gb_cpu_sequencer;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    gb_cpu_sequencer_if #(.MAX_MCYCLES(6), .TCYCLES_PER_M(4)) bif ();

    gb_cpu_sequencer #(
        .MAX_MCYCLES  (6),
        .TCYCLES_PER_M(4),
        .HALT_OPCODE  (8'h76),
        .CB_OPCODE    (8'hCB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to the negedge inside the last T-cycle of the current M-cycle
    task automatic to_mend();
        int k;
        k = 0;
        while (bif.tcycle_idx !== 2'd3 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("mend_reached", 32'(bif.tcycle_idx), 32'd3);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n           = 1'b0;
        bif.opcode_in   = 8'h00;
        bif.sched_len   = 3'd1;
        bif.cond_fail   = 1'b0;
        bif.irq_pending = 1'b0;
        bif.ime         = 1'b0;

        // ---- reset values ----
        @(negedge clk);
        chk("rst_ir",     32'(bif.ir_opcode),  32'h00);
        chk("rst_cb",     32'(bif.cb_prefix),  32'd0);
        chk("rst_isr",    32'(bif.isr_cmd),    32'd0);
        chk("rst_midx",   32'(bif.mcycle_idx), 32'd0);
        chk("rst_tidx",   32'(bif.tcycle_idx), 32'd0);
        chk("rst_halted", 32'(bif.halted),     32'd0);
        chk("rst_err",    32'(bif.sched_err),  32'd0);
        chk("rst_pcinc",  32'(bif.pc_inc),     32'd0);
        chk("rst_done",   32'(bif.instr_done), 32'd0);

        // ---- NOP fetches 3C; pc_inc on the 3rd clock after release ----
        @(negedge clk);
        rst_n         = 1'b1;
        bif.opcode_in = 8'h3C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("nop_tidx",  32'(bif.tcycle_idx), 32'd3);
        chk("nop_pcinc", 32'(bif.pc_inc),     32'd1);
        chk("nop_done",  32'(bif.instr_done), 32'd1);
        chk("nop_fetch", 32'(bif.fetch_en),   32'd1);
        chk("nop_mlast", 32'(bif.m_last),     32'd1);
        nxt();
        chk("ir_3c",     32'(bif.ir_opcode),  32'h3C);
        chk("3c_midx",   32'(bif.mcycle_idx), 32'd0);
        chk("3c_pcinc0", 32'(bif.pc_inc),     32'd0);

        // ---- 3C (1 M) fetches C2: jp nz, 4 M, condition fails at idx 2 ----
        bif.opcode_in = 8'hC2;
        to_mend();
        chk("3c_pcinc", 32'(bif.pc_inc), 32'd1);
        nxt();
        chk("ir_c2", 32'(bif.ir_opcode), 32'hC2);
        bif.sched_len = 3'd4;
        bif.opcode_in = 8'hCB;
        to_mend();
        chk("jp_m0_idx",   32'(bif.mcycle_idx), 32'd0);
        chk("jp_m0_last",  32'(bif.m_last),     32'd0);
        chk("jp_m0_fetch", 32'(bif.fetch_en),   32'd0);
        chk("jp_m0_pcinc", 32'(bif.pc_inc),     32'd0);
        nxt();
        to_mend();
        chk("jp_m1_idx",  32'(bif.mcycle_idx), 32'd1);
        chk("jp_m1_last", 32'(bif.m_last),     32'd0);
        nxt();
        bif.cond_fail = 1'b1;
        #1;
        chk("jp_m2_idx",  32'(bif.mcycle_idx), 32'd2);
        chk("jp_m2_last", 32'(bif.m_last),     32'd1);
        to_mend();
        chk("jp_m2_done",  32'(bif.instr_done), 32'd1);
        chk("jp_m2_pcinc", 32'(bif.pc_inc),     32'd1);
        nxt();
        bif.cond_fail = 1'b0;
        chk("ir_cb",     32'(bif.ir_opcode),  32'hCB);
        chk("cb_midx",   32'(bif.mcycle_idx), 32'd0);
        chk("cb_flag0",  32'(bif.cb_prefix),  32'd0);

        // ---- CB prefix with pending IRQ: operand fetched, ISR deferred ----
        bif.irq_pending = 1'b1;
        bif.ime         = 1'b1;
        bif.opcode_in   = 8'h37;
        to_mend();
        chk("pfx_mlast", 32'(bif.m_last),     32'd1);
        chk("pfx_pcinc", 32'(bif.pc_inc),     32'd1);
        chk("pfx_done",  32'(bif.instr_done), 32'd1);
        nxt();
        chk("cbop_ir",  32'(bif.ir_opcode), 32'h37);
        chk("cbop_cb",  32'(bif.cb_prefix), 32'd1);
        chk("cbop_isr", 32'(bif.isr_cmd),   32'd0);
        bif.sched_len = 3'd2;
        to_mend();
        chk("cbop_m0_pcinc", 32'(bif.pc_inc), 32'd0);
        nxt();
        to_mend();
        chk("cbop_m1_idx",   32'(bif.mcycle_idx), 32'd1);
        chk("cbop_m1_done",  32'(bif.instr_done), 32'd1);
        chk("cbop_m1_pcinc", 32'(bif.pc_inc),     32'd0);
        nxt();
        chk("isr1_isr", 32'(bif.isr_cmd),   32'd1);
        chk("isr1_ir",  32'(bif.ir_opcode), 32'h37);
        chk("isr1_cb",  32'(bif.cb_prefix), 32'd0);

        // ---- ISR of 5 M-cycles; cond_fail must not cut it short ----
        bif.sched_len   = 3'd5;
        bif.irq_pending = 1'b0;
        bif.ime         = 1'b0;
        bif.cond_fail   = 1'b1;
        bif.opcode_in   = 8'h76;
        for (int i = 0; i < 4; i++) begin
            to_mend();
            chk("isr1_idx",   32'(bif.mcycle_idx), 32'(i));
            chk("isr1_mlast", 32'(bif.m_last),     32'd0);
            chk("isr1_pcinc", 32'(bif.pc_inc),     32'd0);
            nxt();
        end
        bif.cond_fail = 1'b0;
        to_mend();
        chk("isr1_m4_idx",   32'(bif.mcycle_idx), 32'd4);
        chk("isr1_m4_last",  32'(bif.m_last),     32'd1);
        chk("isr1_m4_pcinc", 32'(bif.pc_inc),     32'd1);
        nxt();
        chk("isr1_end_isr", 32'(bif.isr_cmd),   32'd0);
        chk("ir_76",        32'(bif.ir_opcode), 32'h76);

        // ---- HALT, wake with ime=0 ----
        bif.sched_len = 3'd1;
        to_mend();
        chk("halt_done",  32'(bif.instr_done), 32'd1);
        chk("halt_pcinc", 32'(bif.pc_inc),     32'd0);
        nxt();
        chk("halted1",      32'(bif.halted),     32'd1);
        chk("halt_fetch",   32'(bif.fetch_en),   32'd1);
        chk("halt_mlast",   32'(bif.m_last),     32'd0);
        chk("halt_midx",    32'(bif.mcycle_idx), 32'd0);
        to_mend();
        chk("halt_m_fetch", 32'(bif.fetch_en),   32'd1);
        chk("halt_m_pcinc", 32'(bif.pc_inc),     32'd0);
        chk("halt_m_done",  32'(bif.instr_done), 32'd0);
        nxt();
        chk("halted_hold",  32'(bif.halted),     32'd1);
        bif.irq_pending = 1'b1;
        bif.opcode_in   = 8'h04;
        to_mend();
        chk("wake0_pcinc", 32'(bif.pc_inc), 32'd1);
        nxt();
        chk("wake0_halted", 32'(bif.halted),    32'd0);
        chk("wake0_ir",     32'(bif.ir_opcode), 32'h04);
        chk("wake0_isr",    32'(bif.isr_cmd),   32'd0);

        // ---- HALT again, wake with ime=1 into a 5 M-cycle ISR ----
        bif.irq_pending = 1'b0;
        bif.opcode_in   = 8'h76;
        to_mend();
        nxt();
        chk("ir_76b", 32'(bif.ir_opcode), 32'h76);
        to_mend();
        nxt();
        chk("halted2", 32'(bif.halted), 32'd1);
        bif.irq_pending = 1'b1;
        bif.ime         = 1'b1;
        bif.sched_len   = 3'd5;
        bif.opcode_in   = 8'hAA;
        to_mend();
        chk("wake1_pcinc", 32'(bif.pc_inc), 32'd0);
        nxt();
        chk("wake1_halted", 32'(bif.halted),    32'd0);
        chk("wake1_isr",    32'(bif.isr_cmd),   32'd1);
        chk("wake1_ir",     32'(bif.ir_opcode), 32'h76);
        bif.irq_pending = 1'b0;
        bif.ime         = 1'b0;
        bif.opcode_in   = 8'h00;
        for (int i = 0; i < 4; i++) begin
            to_mend();
            chk("isr2_done", 32'(bif.instr_done), 32'd0);
            nxt();
        end
        to_mend();
        chk("isr2_end_done",  32'(bif.instr_done), 32'd1);
        chk("isr2_end_pcinc", 32'(bif.pc_inc),     32'd1);
        nxt();
        chk("isr2_isr", 32'(bif.isr_cmd),   32'd0);
        chk("isr2_ir",  32'(bif.ir_opcode), 32'h00);
        chk("err_pre",  32'(bif.sched_err), 32'd0);

        // ---- out-of-range schedule lengths ----
        bif.sched_len = 3'd0;
        to_mend();
        chk("len0_mlast", 32'(bif.m_last),     32'd1);
        chk("len0_done",  32'(bif.instr_done), 32'd1);
        nxt();
        chk("len0_err", 32'(bif.sched_err), 32'd1);
        bif.sched_len = 3'd7;
        bif.opcode_in = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            to_mend();
            chk("len7_idx",   32'(bif.mcycle_idx), 32'(i));
            chk("len7_mlast", 32'(bif.m_last),     32'd0);
            nxt();
        end
        to_mend();
        chk("len7_m5_idx",   32'(bif.mcycle_idx), 32'd5);
        chk("len7_m5_last",  32'(bif.m_last),     32'd1);
        chk("len7_m5_pcinc", 32'(bif.pc_inc),     32'd1);
        nxt();
        chk("len7_ir",  32'(bif.ir_opcode), 32'h3C);
        chk("err_hold", 32'(bif.sched_err), 32'd1);

        // ---- async reset at idx 3 of a 6 M-cycle op ----
        bif.sched_len = 3'd6;
        for (int i = 0; i < 3; i++) begin
            to_mend();
            nxt();
        end
        chk("prerst_idx", 32'(bif.mcycle_idx), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ir",     32'(bif.ir_opcode),  32'h00);
        chk("arst_midx",   32'(bif.mcycle_idx), 32'd0);
        chk("arst_tidx",   32'(bif.tcycle_idx), 32'd0);
        chk("arst_err",    32'(bif.sched_err),  32'd0);
        chk("arst_halted", 32'(bif.halted),     32'd0);
        chk("arst_pcinc",  32'(bif.pc_inc),     32'd0);
        chk("arst_done",   32'(bif.instr_done), 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        bif.sched_len = 3'd1;
        bif.opcode_in = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rel_pcinc", 32'(bif.pc_inc),    32'd1);
        chk("rel_ir",    32'(bif.ir_opcode), 32'h00);
        nxt();
        chk("rel_ir11",  32'(bif.ir_opcode), 32'h11);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/gb_cpu_sequencer.md
Name: gb_cpu_sequencer

Overview:
- M-cycle/T-cycle sequencer that drives the instruction decoder and steps the CPU through each decoded schedule.
- Owns the instruction register (IR), the CB-prefix latch, the ISR-dispatch flag and the HALT state.
- Generalises single-opcode decode to multi-cycle sequencing: variable instruction length, early termination on a failed condition, and fetch/execute overlap.
- Sits between the bus/fetch path and the decoder; its outputs feed the decoder inputs and the datapath control.

Parameters:
MAX_MCYCLES, 6, longest schedule in M-cycles; LEN_W = $clog2(MAX_MCYCLES+1) and IDX_W = $clog2(MAX_MCYCLES) are derived.
TCYCLES_PER_M, 4, T-cycles per M-cycle (>=2).
HALT_OPCODE, 8'h76, opcode that enters HALT.
CB_OPCODE, 8'hCB, prefix opcode.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
opcode_in  in  8  byte returned by the bus fetch; valid at the final T-cycle of a fetch M-cycle
sched_len  in  LEN_W  M-cycle length of the current schedule, from the decoder
cond_fail  in  1  branch condition false; sampled at M-cycle end; ends the instruction early
irq_pending  in  1  enabled interrupt requested (IE&IF != 0)
ime  in  1  interrupt master enable
ir_opcode  out  8  current IR, to decoder
cb_prefix  out  1  IR is CB-prefixed, to decoder
isr_cmd  out  1  ISR schedule active, to decoder
mcycle_idx  out  IDX_W  current M-cycle within the instruction
tcycle_idx  out  $clog2(TCYCLES_PER_M)  current T-cycle
m_last  out  1  current M-cycle is the instruction's last
fetch_en  out  1  bus fetch at PC this M-cycle
pc_inc  out  1  one-cycle pulse: opcode_in latched into IR this clock, increment PC
instr_done  out  1  one-cycle pulse at end of each instruction/ISR
halted  out  1  HALT state
sched_err  out  1  sticky: sched_len was 0 or > MAX_MCYCLES

Behaviour:
- Async reset (rst_n=0): ir_opcode=8'h00 (NOP), cb_prefix=0, isr_cmd=0, mcycle_idx=0, tcycle_idx=0, halted=0, sched_err=0. Pulses are low.
- Reset mid-instruction aborts immediately. The first M-cycle after reset executes the NOP, which fetches the first opcode.
- tcycle_idx free-runs 0..TCYCLES_PER_M-1 and wraps. m_end = (tcycle_idx==TCYCLES_PER_M-1). All state below updates only on m_end.
- eff_len = 1 if sched_len==0; MAX_MCYCLES if sched_len>MAX_MCYCLES; else sched_len. Either out-of-range case sets sched_err.
- States: EXEC, HALT.
- EXEC:
  - m_last = (mcycle_idx==eff_len-1) | cond_fail.
  - fetch_en = m_last.
  - m_end with !m_last: mcycle_idx++.
  - m_end with m_last: instr_done=1, mcycle_idx<=0, then the first matching rule applies:
  - (a) isr_cmd=1: isr_cmd<=0, IR<=opcode_in, cb_prefix<=0, pc_inc.
  - (b) IR==CB_OPCODE && !cb_prefix && !isr_cmd: cb_prefix<=1, IR<=opcode_in, pc_inc. Interrupts are never taken between prefix and operand. The prefix is 1 M-cycle regardless of sched_len.
  - (c) IR==HALT_OPCODE && !cb_prefix: if irq_pending, proceed as (d)/(e); else go to HALT, halted<=1, no pc_inc.
  - (d) irq_pending && ime: isr_cmd<=1, cb_prefix<=0, IR unchanged, opcode_in discarded, no pc_inc.
  - (e) otherwise: IR<=opcode_in, cb_prefix<=0, pc_inc.
- cond_fail is ignored when isr_cmd=1 and on the CB prefix cycle.
- HALT:
  - mcycle_idx holds 0; fetch_en=1 every M-cycle (re-read PC); m_last=0.
  - At m_end with irq_pending: halted<=0, return to EXEC. If ime, isr_cmd<=1 with no pc_inc; else IR<=opcode_in with pc_inc.
  - No irq_pending: remain in HALT.
- pc_inc and instr_done are high only during the single clock that ends the M-cycle.

Test Plan:
- Reset, then opcode_in=8'h3C, sched_len=1 -> pc_inc at clk 3 (TCYCLES_PER_M=4); ir_opcode=8'h3C; instr_done pulse; mcycle_idx stays 0.
- IR=8'hC2 (jp nz), sched_len=4, cond_fail asserted during mcycle_idx=2 -> m_last=1 at idx 2; instruction ends after 3 M-cycles; next IR loaded; mcycle_idx=0.
- IR=8'hCB, then opcode_in=8'h37 with irq_pending=1, ime=1 -> cb_prefix=1, ir_opcode=8'h37, isr_cmd=0. ISR starts only after the CB op completes; IR is held; no pc_inc at that boundary.
- IR=8'h76, irq_pending=0 -> halted=1 with fetch_en every M-cycle. Assert irq_pending, ime=0 -> halted=0, IR<=opcode_in, pc_inc. Repeat with ime=1 -> isr_cmd=1 for 5 M-cycles (sched_len=5), then normal fetch.
- sched_len=0, then sched_len=7 -> each treated as 1 and 6 M-cycles respectively; sched_err=1 stays set until reset.
- Assert rst_n=0 at mcycle_idx=3 of a 6-cycle op -> all outputs at reset values immediately (before the next clk edge); NOP fetch resumes after release.
